alu_wb_stage: RTL and testbench
===============================

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath width (ALU result, memory data, branch target).
REQ-002 The block SHALL have parameter RA_W, default 6, meaning register-file address width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ex_valid  input  1  EX slot holds a real instruction this cycle.
REQ-007 ex_alu_out  input  DATA_W  ALU result.
REQ-008 ex_zero, ex_neg  input  1 each  ALU zero and negative flags for ex_alu_out.
REQ-009 ex_mem_rdata  input  DATA_W  data-memory read data for loads.
REQ-010 ex_mem_to_reg  input  1  1 = write back ex_mem_rdata, 0 = ex_alu_out.
REQ-011 ex_reg_write, ex_rd  input  1 / RA_W  write-enable and destination register.
REQ-012 ex_flag_upd  input  1  instruction updates the Z/N flag register.
REQ-013 ex_br_type  input  2  00 none, 01 BRZ, 10 BRN, 11 JUMP.
REQ-014 ex_br_target  input  DATA_W  branch/jump destination address.
REQ-015 stall, flush  input  1 each  hold pipeline / kill instruction being captured.
REQ-016 wb_valid, wb_reg_write, wb_rd, wb_data  output  1/1/RA_W/DATA_W  registered write-back port to the register file.
REQ-017 flag_z, flag_n  output  1 each  architectural flag register.
REQ-018 br_taken, br_target  output  1 / DATA_W  registered PC redirect to fetch.

Function
REQ-019 Latency SHALL be exactly one cycle: an EX instruction captured at edge k appears on wb_* and br_* after edge k.
REQ-020 Capture SHALL occur when stall=0; wb_valid <= ex_valid & ~flush.
REQ-021 wb_data SHALL be ex_mem_to_reg ? ex_mem_rdata : ex_alu_out, selected before the register.
REQ-022 wb_reg_write SHALL be ex_reg_write & ex_valid & ~flush; wb_reg_write never 1 while wb_valid=0.
REQ-023 Flags SHALL update to {ex_zero, ex_neg} only on a capture edge with ex_valid=1, ex_flag_upd=1, flush=0; otherwise hold.
REQ-024 Branch decision SHALL use flag_z/flag_n as held before the capturing edge, never the same instruction's ex_zero/ex_neg.
REQ-025 br_taken <= ex_valid & ~flush & (JUMP | (BRZ & flag_z) | (BRN & flag_n)); br_target <= ex_br_target whenever capturing.
REQ-026 br_taken SHALL be a one-cycle pulse per qualifying instruction; it drops on the next capture edge.
REQ-027 stall=1 SHALL hold every register (wb_*, flags, br_*) unchanged, including br_taken.
REQ-028 stall=1 and flush=1 together: flush SHALL win -- a bubble is captured (wb_valid=0, wb_reg_write=0, br_taken=0, flags held).
REQ-029 ex_valid=0 SHALL produce a bubble identical to a flush, with wb_data/wb_rd/br_target don't-care.
REQ-030 An instruction with ex_br_type!=00 and ex_flag_upd=1 SHALL both update flags and resolve the branch on pre-update flags.

Reset
REQ-031 rst_n low SHALL immediately force wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, flag_z=0, flag_n=0, br_taken=0, br_target=0, regardless of clk.
REQ-032 Reset asserted mid-stall or mid-branch SHALL discard the held instruction; first capture after release obeys REQ-020.

Structure
REQ-033 Branch-type encodings (BR_NONE, BR_Z, BR_N, BR_JUMP) SHALL live in the shared CPU package, shared with the decoder.
REQ-034 One sub-module SHALL be instantiated: br_resolve (combinational flag/type -> taken); all state stays in alu_wb_stage.

Verification
REQ-035 Reset: rst_n=0 mid-cycle with wb_valid=1 -> all outputs 0 immediately, before the next clk.
REQ-036 ALU writeback: ex_alu_out=0x0000_0005, rd=3, reg_write=1, mem_to_reg=0 -> next cycle wb_data=5, wb_rd=3, wb_reg_write=1.
REQ-037 Flag then branch: SUB giving 0 (ex_zero=1, flag_upd=1), then BRZ target 0x40 -> flag_z=1 after first edge, br_taken=1, br_target=0x40 after second edge.
REQ-038 Same-instruction rule: flag_z=0, BRZ with ex_zero=1 and flag_upd=1 -> br_taken=0, flag_z becomes 1.
REQ-039 Stall/flush: hold stall=1 for 3 cycles after load of 0xDEAD_BEEF -> wb_data stable; then stall=1, flush=1 -> wb_valid=0, flags unchanged.
REQ-040 JUMP with ex_valid=0 -> br_taken stays 0; JUMP with ex_valid=1 -> br_taken pulses exactly one cycle.

Source files
------------

// File: rtl/alu_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wb_stage_pkg
//  Description : Shared CPU definitions (branch-type encodings) used by the
//                decoder and the write-back stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_wb_stage_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_Z    = 2'b01,
        BR_N    = 2'b10,
        BR_JUMP = 2'b11
    } br_type_e;

endpackage
`default_nettype wire

// File: rtl/alu_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wb_stage_if
//  Description : EX-to-WB bundle, pipeline control and write-back/redirect
//                outputs of the write-back stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 6
);
    import alu_wb_stage_pkg::*;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_out;
    logic              ex_zero;
    logic              ex_neg;
    logic [DATA_W-1:0] ex_mem_rdata;
    logic              ex_mem_to_reg;
    logic              ex_reg_write;
    logic [RA_W-1:0]   ex_rd;
    logic              ex_flag_upd;
    br_type_e          ex_br_type;
    logic [DATA_W-1:0] ex_br_target;
    logic              stall;
    logic              flush;

    logic              wb_valid;
    logic              wb_reg_write;
    logic [RA_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flag_z;
    logic              flag_n;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;

    modport master (
        output ex_valid, ex_alu_out, ex_zero, ex_neg, ex_mem_rdata,
               ex_mem_to_reg, ex_reg_write, ex_rd, ex_flag_upd,
               ex_br_type, ex_br_target, stall, flush,
        input  wb_valid, wb_reg_write, wb_rd, wb_data,
               flag_z, flag_n, br_taken, br_target
    );

    modport slave (
        input  ex_valid, ex_alu_out, ex_zero, ex_neg, ex_mem_rdata,
               ex_mem_to_reg, ex_reg_write, ex_rd, ex_flag_upd,
               ex_br_type, ex_br_target, stall, flush,
        output wb_valid, wb_reg_write, wb_rd, wb_data,
               flag_z, flag_n, br_taken, br_target
    );

endinterface
`default_nettype wire

// File: rtl/alu_wb_stage_br_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : br_resolve
//  Description : Combinational branch decision from branch type and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module br_resolve
    import alu_wb_stage_pkg::*;
(
    input  br_type_e i_br_type,
    input  logic     i_flag_z,
    input  logic     i_flag_n,
    output logic     o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_br_type)
            BR_NONE: o_taken = 1'b0;
            BR_Z:    o_taken = i_flag_z;
            BR_N:    o_taken = i_flag_n;
            BR_JUMP: o_taken = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wb_stage
//  Description : One-cycle ALU/memory write-back stage with Z/N flag register
//                and registered PC redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 6
) (
    input  wire            clk,
    input  wire            rst_n,
    alu_wb_stage_if.slave  bus
);

    logic              w_capture;
    logic              w_live;
    logic              w_taken;
    logic [DATA_W-1:0] w_wb_data;

    logic              r_wb_valid;
    logic              r_wb_reg_write;
    logic [RA_W-1:0]   r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_flag_z;
    logic              r_flag_n;
    logic              r_br_taken;
    logic [DATA_W-1:0] r_br_target;

    // Flush overrides stall so that a bubble is always loaded when killing.
    assign w_capture = ~bus.stall | bus.flush;
    assign w_live    = bus.ex_valid & ~bus.flush;
    assign w_wb_data = bus.ex_mem_to_reg ? bus.ex_mem_rdata : bus.ex_alu_out;

    // Decision reads the held flag register, not this instruction's flags.
    br_resolve u_br_resolve (
        .i_br_type (bus.ex_br_type),
        .i_flag_z  (r_flag_z),
        .i_flag_n  (r_flag_n),
        .o_taken   (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_flag_z       <= 1'b0;
            r_flag_n       <= 1'b0;
            r_br_taken     <= 1'b0;
            r_br_target    <= '0;
        end else if (w_capture) begin
            r_wb_valid     <= w_live;
            r_wb_reg_write <= w_live & bus.ex_reg_write;
            r_wb_rd        <= bus.ex_rd;
            r_wb_data      <= w_wb_data;
            r_br_taken     <= w_live & w_taken;
            r_br_target    <= bus.ex_br_target;
            if (w_live && bus.ex_flag_upd) begin
                r_flag_z <= bus.ex_zero;
                r_flag_n <= bus.ex_neg;
            end
        end
    end

    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_reg_write = r_wb_reg_write;
    assign bus.wb_rd        = r_wb_rd;
    assign bus.wb_data      = r_wb_data;
    assign bus.flag_z       = r_flag_z;
    assign bus.flag_n       = r_flag_n;
    assign bus.br_taken     = r_br_taken;
    assign bus.br_target    = r_br_target;

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_wb_stage
//  Description : Directed self-checking bench for alu_wb_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wb_stage;
    import alu_wb_stage_pkg::*;

    localparam int c_DATA_W = 32;
    localparam int c_RA_W   = 6;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    alu_wb_stage_if #(.DATA_W(c_DATA_W), .RA_W(c_RA_W)) bus ();

    alu_wb_stage #(.DATA_W(c_DATA_W), .RA_W(c_RA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_out    = '0;
        bus.ex_zero       = 1'b0;
        bus.ex_neg        = 1'b0;
        bus.ex_mem_rdata  = '0;
        bus.ex_mem_to_reg = 1'b0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_rd         = '0;
        bus.ex_flag_upd   = 1'b0;
        bus.ex_br_type    = BR_NONE;
        bus.ex_br_target  = '0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wb_valid"},     64'(bus.wb_valid),     64'h0);
        check({tag, ".wb_reg_write"}, 64'(bus.wb_reg_write), 64'h0);
        check({tag, ".wb_rd"},        64'(bus.wb_rd),        64'h0);
        check({tag, ".wb_data"},      64'(bus.wb_data),      64'h0);
        check({tag, ".flag_z"},       64'(bus.flag_z),       64'h0);
        check({tag, ".flag_n"},       64'(bus.flag_n),       64'h0);
        check({tag, ".br_taken"},     64'(bus.br_taken),     64'h0);
        check({tag, ".br_target"},    64'(bus.br_target),    64'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;

        // ALU write-back
        bus.ex_valid = 1'b1; bus.ex_alu_out = 32'h0000_0005; bus.ex_rd = 6'd3;
        bus.ex_reg_write = 1'b1;
        step();
        check("alu.wb_valid",     64'(bus.wb_valid),     64'h1);
        check("alu.wb_data",      64'(bus.wb_data),      64'h5);
        check("alu.wb_rd",        64'(bus.wb_rd),        64'h3);
        check("alu.wb_reg_write", 64'(bus.wb_reg_write), 64'h1);

        // Load selects memory data
        idle();
        bus.ex_valid = 1'b1; bus.ex_alu_out = 32'h9; bus.ex_mem_rdata = 32'h1234;
        bus.ex_mem_to_reg = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 6'd10;
        step();
        check("load.wb_data", 64'(bus.wb_data), 64'h1234);
        check("load.wb_rd",   64'(bus.wb_rd),   64'ha);

        // SUB -> 0 sets Z, then BRZ taken
        idle();
        bus.ex_valid = 1'b1; bus.ex_zero = 1'b1; bus.ex_flag_upd = 1'b1;
        bus.ex_reg_write = 1'b1; bus.ex_rd = 6'd1;
        step();
        check("sub.flag_z",   64'(bus.flag_z),   64'h1);
        check("sub.br_taken", 64'(bus.br_taken), 64'h0);
        idle();
        bus.ex_valid = 1'b1; bus.ex_br_type = BR_Z; bus.ex_br_target = 32'h40;
        step();
        check("brz.br_taken",     64'(bus.br_taken),     64'h1);
        check("brz.br_target",    64'(bus.br_target),    64'h40);
        check("brz.wb_reg_write", 64'(bus.wb_reg_write), 64'h0);
        idle();
        step();
        check("brz.pulse_end", 64'(bus.br_taken), 64'h0);

        // Same-instruction rule: clear Z, then BRZ that itself sets Z
        bus.ex_valid = 1'b1; bus.ex_flag_upd = 1'b1;
        step();
        check("clr.flag_z", 64'(bus.flag_z), 64'h0);
        idle();
        bus.ex_valid = 1'b1; bus.ex_br_type = BR_Z; bus.ex_zero = 1'b1;
        bus.ex_flag_upd = 1'b1; bus.ex_br_target = 32'h80;
        step();
        check("same.br_taken", 64'(bus.br_taken), 64'h0);
        check("same.flag_z",   64'(bus.flag_z),   64'h1);

        // Set N (clears Z), then BRN taken, BRZ not taken
        idle();
        bus.ex_valid = 1'b1; bus.ex_neg = 1'b1; bus.ex_flag_upd = 1'b1;
        step();
        check("neg.flag_n", 64'(bus.flag_n), 64'h1);
        check("neg.flag_z", 64'(bus.flag_z), 64'h0);
        idle();
        bus.ex_valid = 1'b1; bus.ex_br_type = BR_N; bus.ex_br_target = 32'h90;
        step();
        check("brn.br_taken",  64'(bus.br_taken),  64'h1);
        check("brn.br_target", 64'(bus.br_target), 64'h90);
        idle();
        bus.ex_valid = 1'b1; bus.ex_br_type = BR_Z; bus.ex_br_target = 32'ha0;
        step();
        check("brz_nt.br_taken", 64'(bus.br_taken), 64'h0);

        // Load 0xDEADBEEF, then stall 3 cycles with changing inputs
        idle();
        bus.ex_valid = 1'b1; bus.ex_mem_to_reg = 1'b1; bus.ex_mem_rdata = 32'hDEAD_BEEF;
        bus.ex_reg_write = 1'b1; bus.ex_rd = 6'd7;
        step();
        check("ld.wb_data", 64'(bus.wb_data), 64'hDEAD_BEEF);
        bus.stall = 1'b1; bus.ex_mem_rdata = 32'h2222; bus.ex_alu_out = 32'h1111;
        bus.ex_rd = 6'd9; bus.ex_flag_upd = 1'b1; bus.ex_zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.wb_data",  64'(bus.wb_data),  64'hDEAD_BEEF);
            check("stall.wb_rd",    64'(bus.wb_rd),    64'h7);
            check("stall.wb_valid", 64'(bus.wb_valid), 64'h1);
            check("stall.flag_z",   64'(bus.flag_z),   64'h0);
        end
        // Stall + flush: bubble captured, flags held (Z=0, N=1)
        bus.flush = 1'b1; bus.ex_br_type = BR_JUMP;
        step();
        check("sflush.wb_valid",     64'(bus.wb_valid),     64'h0);
        check("sflush.wb_reg_write", 64'(bus.wb_reg_write), 64'h0);
        check("sflush.br_taken",     64'(bus.br_taken),     64'h0);
        check("sflush.flag_z",       64'(bus.flag_z),       64'h0);
        check("sflush.flag_n",       64'(bus.flag_n),       64'h1);

        // JUMP with ex_valid=0 is a bubble
        idle();
        bus.ex_br_type = BR_JUMP; bus.ex_reg_write = 1'b1; bus.ex_br_target = 32'h100;
        step();
        check("jinv.br_taken",     64'(bus.br_taken),     64'h0);
        check("jinv.wb_valid",     64'(bus.wb_valid),     64'h0);
        check("jinv.wb_reg_write", 64'(bus.wb_reg_write), 64'h0);

        // Valid JUMP pulses one cycle; stall holds the pulse
        bus.ex_valid = 1'b1;
        step();
        check("jmp.br_taken",  64'(bus.br_taken),  64'h1);
        check("jmp.br_target", 64'(bus.br_target), 64'h100);
        bus.stall = 1'b1;
        step();
        check("jmp.stall_hold", 64'(bus.br_taken), 64'h1);
        idle();
        step();
        check("jmp.pulse_end", 64'(bus.br_taken), 64'h0);

        // Asynchronous reset mid-cycle
        bus.ex_valid = 1'b1; bus.ex_alu_out = 32'h77; bus.ex_reg_write = 1'b1;
        bus.ex_rd = 6'd5; bus.ex_flag_upd = 1'b1; bus.ex_neg = 1'b1;
        bus.ex_br_type = BR_JUMP; bus.ex_br_target = 32'h200;
        step();
        check("pre_rst.wb_valid", 64'(bus.wb_valid), 64'h1);
        bus.stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #1 rst_n = 1'b1;
        step();
        check("post_rst.stalled_valid", 64'(bus.wb_valid), 64'h0);
        idle();
        bus.ex_valid = 1'b1; bus.ex_alu_out = 32'h33; bus.ex_reg_write = 1'b1; bus.ex_rd = 6'd2;
        step();
        check("post_rst.wb_valid", 64'(bus.wb_valid), 64'h1);
        check("post_rst.wb_data",  64'(bus.wb_data),  64'h33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
